// File: rtl/xlr8_vol_ramp_regs.sv
// xlr8_vol_ramp_regs
//
// This block maps per-channel target-volume registers into AVR data memory.
// It also maps one control register and one status register. Each channel's
// output volume moves toward its effective target by one LSB per prescaler
// tick, so volume changes do not click. The ramp can be bypassed, or every
// channel can be muted, through the control register.
//
// Register map (offsets from BASE_ADDR):
//   0 .. NUM_CH-1 : channel target volume, WIDTH bits, read/write
//   NUM_CH        : CTRL   {6'b0, RAMP_EN, MUTE}, read/write (bits [1:0])
//   NUM_CH+1      : STATUS zero-extended ramp_busy, read-only
//
// Ports:
//   clk, rst       : single clock; synchronous active-high reset
//   clken          : AVR clock enable, qualifies register writes only
//   dbus_in        : AVR write data
//   dbus_out       : combinational read data, 0 when no owned address selected
//   io_out_en      : high while an owned address is read
//   ramadr         : DM address
//   ramre, ramwe   : DM read / write enables
//   dm_sel         : DM select
//   vol_out        : current volumes, channel i at [i*WIDTH +: WIDTH]
//   ramp_busy      : bit i high while channel i differs from its effective target
module xlr8_vol_ramp_regs #(
  parameter int BASE_ADDR = 0,
  parameter int NUM_CH    = 2,
  parameter int WIDTH     = 8,
  parameter int RAMP_DIV  = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clken,
  input  logic [7:0]              dbus_in,
  output logic [7:0]              dbus_out,
  output logic                    io_out_en,
  input  logic [7:0]              ramadr,
  input  logic                    ramre,
  input  logic                    ramwe,
  input  logic                    dm_sel,
  output logic [NUM_CH*WIDTH-1:0] vol_out,
  output logic [NUM_CH-1:0]       ramp_busy
);

  localparam int CNT_W   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int NUM_REG = NUM_CH + 2;

  logic [NUM_REG-1:0] sel;
  logic               wrEn;
  logic               tick;

  logic [WIDTH-1:0]   target_q [NUM_CH];
  logic [WIDTH-1:0]   target_d [NUM_CH];
  logic [WIDTH-1:0]   cur_q    [NUM_CH];
  logic [WIDTH-1:0]   cur_d    [NUM_CH];
  logic [WIDTH-1:0]   effOld   [NUM_CH];
  logic [WIDTH-1:0]   effNew   [NUM_CH];
  logic [1:0]         ctrl_q, ctrl_d;
  logic [NUM_CH-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Only the low bits of the write bus land in registers.
  logic unusedBits;
  assign unusedBits = ^dbus_in;

  always_comb begin
    for (int k = 0; k < NUM_REG; k++) begin
      sel[k] = dm_sel && (ramadr == 8'(BASE_ADDR + k));
    end
  end

  assign wrEn = clken && ramwe;

  // The free-running prescaler wraps at RAMP_DIV-1. When RAMP_DIV is 1 it stays
  // at 0, so a tick occurs on every cycle.
  always_comb begin
    tick  = (cnt_q == CNT_W'(RAMP_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  // The ramp step uses the pre-write target and CTRL, so a write that lands on
  // a tick cycle takes effect from the following cycle. ramp_busy compares the
  // next current value against the post-write effective target.
  always_comb begin
    ctrl_d = (wrEn && sel[NUM_CH]) ? dbus_in[1:0] : ctrl_q;
    busy_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      target_d[i] = (wrEn && sel[i]) ? dbus_in[WIDTH-1:0] : target_q[i];
      effOld[i]   = ctrl_q[0] ? '0 : target_q[i];
      effNew[i]   = ctrl_d[0] ? '0 : target_d[i];
      cur_d[i]    = cur_q[i];
      if (!ctrl_q[1]) begin
        cur_d[i] = effOld[i];
      end else if (tick) begin
        if (cur_q[i] < effOld[i]) begin
          cur_d[i] = cur_q[i] + WIDTH'(1);
        end else if (cur_q[i] > effOld[i]) begin
          cur_d[i] = cur_q[i] - WIDTH'(1);
        end
      end
      busy_d[i] = (cur_d[i] != effNew[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= 2'b10;
      busy_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        target_q[i] <= '0;
        cur_q[i]    <= '0;
      end
    end else begin
      ctrl_q <= ctrl_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      for (int i = 0; i < NUM_CH; i++) begin
        target_q[i] <= target_d[i];
        cur_q[i]    <= cur_d[i];
      end
    end
  end

  // The read mux is combinational. It is not qualified by clken, and only
  // io_out_en depends on ramre.
  always_comb begin
    dbus_out = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel[i]) begin
        dbus_out = 8'(target_q[i]);
      end
    end
    if (sel[NUM_CH]) begin
      dbus_out = {6'b0, ctrl_q};
    end
    if (sel[NUM_CH+1]) begin
      dbus_out = 8'(busy_q);
    end
    io_out_en = ramre && (|sel);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : gVol
    assign vol_out[g*WIDTH +: WIDTH] = cur_q[g];
  end

  assign ramp_busy = busy_q;

endmodule

// File: tb/tb_xlr8_vol_ramp_regs.sv
// tb_xlr8_vol_ramp_regs
//
// Self-checking bench for xlr8_vol_ramp_regs. It uses two channels of 8 bits,
// a ramp divider of 4, and base address 0x40. A behavioural model tracks the
// register contents and volumes with plain integers. A negedge compare
// process checks every output against that model. Literal expectations are
// interleaved with the directed scenarios.
module tb_xlr8_vol_ramp_regs;

  localparam int BASE = 8'h40;
  localparam int NCH  = 2;
  localparam int W    = 8;
  localparam int DIV  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              clken;
  logic [7:0]        dbus_in;
  logic [7:0]        dbus_out;
  logic              io_out_en;
  logic [7:0]        ramadr;
  logic              ramre;
  logic              ramwe;
  logic              dm_sel;
  logic [NCH*W-1:0]  vol_out;
  logic [NCH-1:0]    ramp_busy;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  // Model state
  int mTgt  [NCH];
  int mCur  [NCH];
  int mBusy [NCH];
  int mCtrl;
  int mCnt;

  xlr8_vol_ramp_regs #(
    .BASE_ADDR(BASE),
    .NUM_CH   (NCH),
    .WIDTH    (W),
    .RAMP_DIV (DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clken    (clken),
    .dbus_in  (dbus_in),
    .dbus_out (dbus_out),
    .io_out_en(io_out_en),
    .ramadr   (ramadr),
    .ramre    (ramre),
    .ramwe    (ramwe),
    .dm_sel   (dm_sel),
    .vol_out  (vol_out),
    .ramp_busy(ramp_busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // The model advances at each clock edge from the inputs held during the
  // preceding cycle. The step uses the old target/CTRL, then writes apply.
  always @(posedge clk) begin
    bit tick;
    int eff;
    int a;
    if (rst) begin
      mCtrl = 2;
      mCnt  = 0;
      for (int i = 0; i < NCH; i++) begin
        mTgt[i] = 0; mCur[i] = 0; mBusy[i] = 0;
      end
    end else begin
      tick = (mCnt == DIV - 1);
      for (int i = 0; i < NCH; i++) begin
        eff = ((mCtrl & 1) != 0) ? 0 : mTgt[i];
        if ((mCtrl & 2) == 0) mCur[i] = eff;
        else if (tick) begin
          if (mCur[i] < eff) mCur[i] = mCur[i] + 1;
          else if (mCur[i] > eff) mCur[i] = mCur[i] - 1;
        end
      end
      if (clken && ramwe && dm_sel) begin
        a = int'(ramadr) - BASE;
        if (a >= 0 && a < NCH) mTgt[a] = int'(dbus_in);
        else if (a == NCH) mCtrl = int'(dbus_in) & 3;
      end
      mCnt = (mCnt + 1) % DIV;
      for (int i = 0; i < NCH; i++) begin
        mBusy[i] = (mCur[i] != (((mCtrl & 1) != 0) ? 0 : mTgt[i])) ? 1 : 0;
      end
    end
  end

  function automatic logic [7:0] modelRead();
    int a;
    logic [7:0] st;
    a = int'(ramadr) - BASE;
    if (!dm_sel) return 8'h00;
    if (a >= 0 && a < NCH) return 8'(mTgt[a]);
    if (a == NCH) return 8'(mCtrl);
    if (a == NCH + 1) begin
      st = '0;
      for (int i = 0; i < NCH; i++) st[i] = mBusy[i][0];
      return st;
    end
    return 8'h00;
  endfunction

  function automatic logic modelEn();
    int a;
    a = int'(ramadr) - BASE;
    return ramre && dm_sel && (a >= 0) && (a <= NCH + 1);
  endfunction

  // The compare process checks all outputs against the model on each negedge.
  always @(negedge clk) begin
    logic [NCH*W-1:0] ev;
    logic [NCH-1:0]   eb;
    if (checkEn) begin
      for (int i = 0; i < NCH; i++) begin
        ev[i*W +: W] = W'(mCur[i]);
        eb[i]        = mBusy[i][0];
      end
      checkOutput("vol_out", 32'(vol_out), 32'(ev));
      checkOutput("ramp_busy", 32'(ramp_busy), 32'(eb));
      checkOutput("dbus_out", 32'(dbus_out), 32'(modelRead()));
      checkOutput("io_out_en", 32'(io_out_en), 32'(modelEn()));
    end
  end

  task automatic setIdle();
    clken = 1'b0; dbus_in = 8'h00; ramadr = 8'h00;
    ramre = 1'b0; ramwe = 1'b0; dm_sel = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // The write task holds a write for one clock edge, then returns at edge+1.
  task automatic applyStimulus(input int addr, input logic [7:0] data, input logic ce);
    ramadr = 8'(addr); dbus_in = data; dm_sel = 1'b1; ramwe = 1'b1; clken = ce;
    @(posedge clk); #1;
    setIdle();
  endtask

  task automatic readReg(input int addr, output logic [7:0] d, output logic en);
    ramadr = 8'(addr); dm_sel = 1'b1; ramre = 1'b1;
    #1;
    d  = dbus_out;
    en = io_out_en;
    #1;
    setIdle();
  endtask

  task automatic randomCycle();
    rst     = ($urandom_range(0, 599) == 0);
    dm_sel  = ($urandom_range(0, 7) != 0);
    ramadr  = 8'(BASE - 1 + int'($urandom_range(0, 6)));
    ramwe   = ($urandom_range(0, 3) == 0);
    ramre   = $urandom_range(0, 1) == 1;
    clken   = ($urandom_range(0, 3) != 0);
    dbus_in = 8'($urandom);
    // Most CTRL writes keep the ramp enabled so that long ramps occur.
    if (int'(ramadr) == BASE + NCH && $urandom_range(0, 3) != 0) dbus_in[1] = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] d;
    logic en;
    int guard;
    rst = 1'b1;
    setIdle();
    @(posedge clk); #1;
    checkEn = 1'b1;
    idle(1);
    rst = 1'b0;

    $display("[TB] reset and read-back");
    checkOutput("lit_vol_reset", 32'(vol_out), 32'h0);
    for (int k = 0; k < NCH + 3; k++) begin
      readReg(BASE + k, d, en);
      if (k < NCH)        checkOutput("lit_tgt_reset", 32'(d), 32'h00);
      else if (k == NCH)  checkOutput("lit_ctrl_reset", 32'(d), 32'h02);
      else                checkOutput("lit_status_or_unowned", 32'(d), 32'h00);
      checkOutput("lit_io_out_en", 32'(en), (k < NCH + 2) ? 32'd1 : 32'd0);
    end

    $display("[TB] ramp ch0 to 5");
    applyStimulus(BASE, 8'h05, 1'b1);
    readReg(BASE + NCH + 1, d, en);
    checkOutput("lit_status_ramping", 32'(d), 32'h01);
    idle(24);
    checkOutput("lit_ch0_at5", 32'(vol_out[7:0]), 32'h05);
    readReg(BASE + NCH + 1, d, en);
    checkOutput("lit_status_done", 32'(d), 32'h00);

    $display("[TB] mute and unmute");
    applyStimulus(BASE + NCH, 8'h03, 1'b1);
    idle(24);
    checkOutput("lit_ch0_muted", 32'(vol_out[7:0]), 32'h00);
    readReg(BASE, d, en);
    checkOutput("lit_tgt_kept", 32'(d), 32'h05);
    applyStimulus(BASE + NCH, 8'h02, 1'b1);
    idle(24);
    checkOutput("lit_ch0_unmuted", 32'(vol_out[7:0]), 32'h05);

    $display("[TB] ramp bypass");
    applyStimulus(BASE + NCH, 8'h00, 1'b1);
    applyStimulus(BASE + 1, 8'hFF, 1'b1);
    idle(1);
    checkOutput("lit_ch1_jump_ff", 32'(vol_out[15:8]), 32'hFF);
    applyStimulus(BASE + 1, 8'h00, 1'b1);
    idle(1);
    checkOutput("lit_ch1_jump_00", 32'(vol_out[15:8]), 32'h00);

    $display("[TB] retarget mid-ramp");
    applyStimulus(BASE, 8'h00, 1'b1);
    applyStimulus(BASE + NCH, 8'h02, 1'b1);
    applyStimulus(BASE, 8'h10, 1'b1);
    guard = 0;
    while (vol_out[7:0] != 8'h06 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("wait_ch0_6", 32'(guard < 200), 32'd1);
    applyStimulus(BASE, 8'h03, 1'b1);
    idle(40);
    checkOutput("lit_ch0_at3", 32'(vol_out[7:0]), 32'h03);

    $display("[TB] ignored writes and reset");
    applyStimulus(BASE + 1, 8'h77, 1'b0);
    readReg(BASE + 1, d, en);
    checkOutput("lit_clken0_ignored", 32'(d), 32'h00);
    applyStimulus(BASE + NCH + 1, 8'hFF, 1'b1);
    readReg(BASE + NCH + 1, d, en);
    checkOutput("lit_status_write_ignored", 32'(d), 32'h00);
    applyStimulus(BASE + 1, 8'h80, 1'b1);
    idle(10);
    rst = 1'b1;
    ramadr = 8'(BASE); dbus_in = 8'h55; dm_sel = 1'b1; ramwe = 1'b1; clken = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    setIdle();
    checkOutput("lit_vol_after_rst", 32'(vol_out), 32'h0);
    checkOutput("lit_busy_after_rst", 32'(ramp_busy), 32'h0);
    readReg(BASE + NCH, d, en);
    checkOutput("lit_ctrl_after_rst", 32'(d), 32'h02);
    readReg(BASE, d, en);
    checkOutput("lit_tgt_after_rst", 32'(d), 32'h00);

    $display("[TB] random traffic");
    repeat (3000) randomCycle();
    rst = 1'b0;
    setIdle();
    idle(4);

    checkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
